// File: rtl/io_ctrl_pkg.sv
// Shared constants for the memory-mapped IO controller: word-select bit
// indices, status bit positions and the compare reset value.
package io_ctrl_pkg;

   localparam int IO_LEDS      = 0;
   localparam int IO_UART_DATA = 1;
   localparam int IO_UART_STAT = 2;
   localparam int IO_TIMER     = 3;
   localparam int IO_TIMER_CMP = 4;

   localparam int ST_BUSY   = 9;
   localparam int ST_PEND   = 10;
   localparam int ST_OVF    = 11;
   localparam int ST_TMATCH = 12;

   localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_tx_fifo.sv
// Circular TX byte buffer. Pushes while full and pops while empty are ignored;
// a push and a pop in the same cycle advance both pointers and keep the count.
module io_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: a zero count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/io_ctrl.sv
// IO controller on the core's memory port: one-hot word decode, LED register,
// buffered UART transmit, free-running timer with sticky compare flag.
module io_ctrl
   import io_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LED_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [31:0]      io_addr,
   input  logic [31:0]      io_wdata,
   input  logic             io_wr,
   output logic [31:0]      io_rdata,
   output logic [LED_W-1:0] leds,
   output logic [7:0]       uart_data,
   output logic             uart_valid,
   input  logic             uart_ready,
   output logic             timer_irq
);

   logic [13:0]              wa;
   logic                     wr_leds, wr_udata, wr_stat, wr_timer, wr_cmp;
   logic                     fifo_empty, fifo_full;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic                     ovf, tmatch;
   logic [31:0]              timer, cmp;
   logic [31:0]              status;
   logic                     unused_ok;

   assign wa       = io_addr[15:2];
   assign wr_leds  = io_wr & wa[IO_LEDS];
   assign wr_udata = io_wr & wa[IO_UART_DATA];
   assign wr_stat  = io_wr & wa[IO_UART_STAT];
   assign wr_timer = io_wr & wa[IO_TIMER];
   assign wr_cmp   = io_wr & wa[IO_TIMER_CMP];

   // Handshake: a byte leaves on every edge where uart_valid and uart_ready
   // are both high; until then uart_data holds the FIFO head unchanged.
   assign uart_valid = ~fifo_empty;
   assign timer_irq  = tmatch;

   io_tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (wr_udata),
      .push_data (io_wdata[7:0]),
      .pop       (uart_valid & uart_ready),
      .head      (uart_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         leds   <= '0;
         ovf    <= 1'b0;
         tmatch <= 1'b0;
         timer  <= '0;
         cmp    <= CMP_RESET;
      end else begin
         if (wr_leds) leds <= io_wdata[LED_W-1:0];
         // A dropped push outranks a simultaneous status-write clear.
         if (wr_udata && fifo_full) ovf <= 1'b1;
         else if (wr_stat)          ovf <= 1'b0;
         timer <= wr_timer ? io_wdata : timer + 32'd1;
         if (wr_cmp) cmp <= io_wdata;
         if (timer == cmp)  tmatch <= 1'b1;
         else if (wr_cmp)   tmatch <= 1'b0;
      end
   end

   always_comb begin
      status            = '0;
      status[ST_BUSY]   = fifo_full;
      status[ST_PEND]   = ~fifo_empty;
      status[ST_OVF]    = ovf;
      status[ST_TMATCH] = tmatch;
   end

   always_comb begin
      io_rdata = '0;
      if (wa[IO_LEDS])      io_rdata = io_rdata | 32'(leds);
      if (wa[IO_UART_STAT]) io_rdata = io_rdata | status;
      if (wa[IO_TIMER])     io_rdata = io_rdata | timer;
      if (wa[IO_TIMER_CMP]) io_rdata = io_rdata | cmp;
   end

   assign unused_ok = ^{io_addr[31:16], io_addr[1:0], wa[13:5], fifo_count};

endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl: directed scenarios plus a randomized run, all checked
// against a queue-based behavioural model of the register map.
module tb_io_ctrl;

   localparam int DEPTH = 4;
   localparam int LED_W = 6;

   logic             clk = 1'b0;
   logic             resetn;
   logic [31:0]      io_addr, io_wdata, io_rdata;
   logic             io_wr, uart_ready;
   logic [LED_W-1:0] leds;
   logic [7:0]       uart_data;
   logic             uart_valid, timer_irq;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]       m_q[$];
   logic [LED_W-1:0] m_leds;
   logic             m_ovf, m_tmatch;
   logic [31:0]      m_timer, m_cmp;

   always #5 clk = ~clk;

   io_ctrl #(.DEPTH(DEPTH), .LED_W(LED_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .io_addr    (io_addr),
      .io_wdata   (io_wdata),
      .io_wr      (io_wr),
      .io_rdata   (io_rdata),
      .leds       (leds),
      .uart_data  (uart_data),
      .uart_valid (uart_valid),
      .uart_ready (uart_ready),
      .timer_irq  (timer_irq)
   );

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] r;
      r = 32'h0;
      if (a[2]) r = r | 32'(m_leds);
      if (a[4]) r = r | {19'b0, m_tmatch, m_ovf, (m_q.size() != 0), (m_q.size() == DEPTH), 9'b0};
      if (a[5]) r = r | m_timer;
      if (a[6]) r = r | m_cmp;
      return r;
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
      io_addr    = a;
      io_wdata   = d;
      io_wr      = w;
      uart_ready = r;
      #1;
   endtask

   // Advance the model by one clock from the inputs currently applied, then clock the DUT.
   task automatic tick();
      logic [4:0] s;
      bit full, pop, push, hit;
      if (!resetn) begin
         m_q.delete();
         m_leds   = '0;
         m_ovf    = 1'b0;
         m_tmatch = 1'b0;
         m_timer  = 32'h0;
         m_cmp    = 32'hFFFF_FFFF;
      end else begin
         s    = io_addr[6:2];
         full = (m_q.size() == DEPTH);
         pop  = (m_q.size() != 0) && uart_ready;
         push = io_wr && s[1];
         hit  = (m_timer == m_cmp);
         if (io_wr && s[0]) m_leds = io_wdata[LED_W-1:0];
         if (io_wr && s[2]) m_ovf = 1'b0;
         if (push && full) m_ovf = 1'b1;
         if (pop) void'(m_q.pop_front());
         if (push && !full) m_q.push_back(io_wdata[7:0]);
         if (io_wr && s[4]) begin
            m_cmp    = io_wdata;
            m_tmatch = 1'b0;
         end
         if (hit) m_tmatch = 1'b1;
         m_timer = (io_wr && s[3]) ? io_wdata : m_timer + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      resetn = 1'b1;
      drive(32'h10, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (io_rdata !== 32'h0) begin
         n_err++; $display("FAIL reset_status: got %h expected %h", io_rdata, 32'h0);
      end
      n_vec++;
      if (uart_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_uart_valid: got %b expected 0", uart_valid);
      end
      n_vec++;
      if (timer_irq !== 1'b0) begin
         n_err++; $display("FAIL reset_timer_irq: got %b expected 0", timer_irq);
      end
      drive(32'h04, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (io_rdata !== 32'h0) begin
         n_err++; $display("FAIL reset_leds_read: got %h expected %h", io_rdata, 32'h0);
      end
      tick();
   endtask

   task automatic test_uart_overflow();
      for (int i = 0; i < 5; i++) begin
         drive(32'h08, 32'h41 + i, 1'b1, 1'b0);
         tick();
      end
      drive(32'h10, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (io_rdata !== 32'hE00) begin
         n_err++; $display("FAIL ovf_status: got %h expected %h", io_rdata, 32'hE00);
      end
      n_vec++;
      if (uart_valid !== 1'b1 || uart_data !== 8'h41) begin
         n_err++; $display("FAIL ovf_head: got valid=%b data=%h expected valid=1 data=41", uart_valid, uart_data);
      end
      tick();
      drive(32'h10, $urandom(), 1'b1, 1'b0);
      tick();
      drive(32'h10, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (io_rdata !== 32'h600) begin
         n_err++; $display("FAIL ovf_clear: got %h expected %h", io_rdata, 32'h600);
      end
      tick();
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         drive(32'h0, 32'h0, 1'b0, 1'b1);
         n_vec++;
         if (uart_valid !== 1'b1 || uart_data !== 8'(8'h41 + i)) begin
            n_err++; $display("FAIL drain_byte%0d: got valid=%b data=%h expected valid=1 data=%h", i, uart_valid, uart_data, 8'(8'h41 + i));
         end
         tick();
      end
      drive(32'h10, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (uart_valid !== 1'b0) begin
         n_err++; $display("FAIL drain_valid: got %b expected 0", uart_valid);
      end
      n_vec++;
      if (io_rdata !== 32'h0) begin
         n_err++; $display("FAIL drain_status: got %h expected %h", io_rdata, 32'h0);
      end
      tick();
   endtask

   task automatic test_push_pop();
      logic [7:0] exp_q[$];
      exp_q = '{8'h61, 8'h62, 8'h55};
      drive(32'h08, 32'h61, 1'b1, 1'b0);
      tick();
      drive(32'h08, 32'h62, 1'b1, 1'b0);
      tick();
      drive(32'h08, 32'h55, 1'b1, 1'b1);
      tick();
      void'(exp_q.pop_front());
      drive(32'h10, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (io_rdata !== 32'h400) begin
         n_err++; $display("FAIL pushpop_status: got %h expected %h", io_rdata, 32'h400);
      end
      for (int i = 0; i < 2; i++) begin
         drive(32'h0, 32'h0, 1'b0, 1'b1);
         n_vec++;
         if (uart_valid !== 1'b1 || uart_data !== exp_q[0]) begin
            n_err++; $display("FAIL pushpop_order%0d: got valid=%b data=%h expected valid=1 data=%h", i, uart_valid, uart_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick();
      end
      drive(32'h0, 32'h0, 1'b0, 1'b1);
      n_vec++;
      if (uart_valid !== 1'b0) begin
         n_err++; $display("FAIL pushpop_empty: got %b expected 0", uart_valid);
      end
      tick();
   endtask

   task automatic test_timer();
      logic [31:0] exp_t[6];
      logic        exp_irq[6];
      exp_t   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h3};
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      drive(32'h40, 32'h1, 1'b1, 1'b0);
      tick();
      drive(32'h20, 32'hFFFF_FFFE, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(32'h20, 32'h0, 1'b0, 1'b0);
         n_vec++;
         if (io_rdata !== exp_t[i] || timer_irq !== exp_irq[i]) begin
            n_err++; $display("FAIL timer_step%0d: got timer=%h irq=%b expected timer=%h irq=%b", i, io_rdata, timer_irq, exp_t[i], exp_irq[i]);
         end
         tick();
      end
      drive(32'h40, 32'h100, 1'b1, 1'b0);
      tick();
      drive(32'h10, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (timer_irq !== 1'b0 || io_rdata !== 32'h0) begin
         n_err++; $display("FAIL timer_clear: got irq=%b status=%h expected irq=0 status=0", timer_irq, io_rdata);
      end
      tick();
   endtask

   task automatic test_multi_select();
      drive(32'h0C, 32'h0000_003F, 1'b1, 1'b0);
      tick();
      drive(32'h04, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (leds !== 6'h3F || io_rdata !== 32'h3F) begin
         n_err++; $display("FAIL multi_leds: got leds=%h read=%h expected leds=3f read=3f", leds, io_rdata);
      end
      n_vec++;
      if (uart_valid !== 1'b1 || uart_data !== 8'h3F) begin
         n_err++; $display("FAIL multi_push: got valid=%b data=%h expected valid=1 data=3f", uart_valid, uart_data);
      end
      drive(32'h0, 32'h0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      for (int n = 0; n < 400; n++) begin
         a = $urandom();
         d = $urandom();
         if ($urandom_range(0, 3) == 0) d = m_timer + 32'($urandom_range(1, 4));
         drive(a, d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
         n_vec++;
         if (io_rdata !== m_read(a)) begin
            n_err++; $display("FAIL rand_rdata@%0d: got %h expected %h (addr %h)", n, io_rdata, m_read(a), a);
         end
         n_vec++;
         if (uart_valid !== (m_q.size() != 0)) begin
            n_err++; $display("FAIL rand_valid@%0d: got %b expected %b", n, uart_valid, (m_q.size() != 0));
         end
         if (m_q.size() != 0) begin
            n_vec++;
            if (uart_data !== m_q[0]) begin
               n_err++; $display("FAIL rand_data@%0d: got %h expected %h", n, uart_data, m_q[0]);
            end
         end
         n_vec++;
         if (leds !== m_leds || timer_irq !== m_tmatch) begin
            n_err++; $display("FAIL rand_outs@%0d: got leds=%h irq=%b expected leds=%h irq=%b", n, leds, timer_irq, m_leds, m_tmatch);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_uart_overflow();
      test_drain();
      test_push_pop();
      test_timer();
      test_multi_select();
      test_random();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/io_ctrl.md
# io_ctrl

Memory-mapped IO controller that sits on the core's IO port (`IO_mem_addr`, `IO_mem_wdata`, `IO_mem_wr`, `IO_mem_rdata`).
- Decodes the word address.
- Holds the LED register.
- Buffers outgoing UART bytes in a small FIFO and sequences them to the UART transmitter over a valid/ready handshake.
- Provides a free-running timer with a compare flag.

Software sees a non-blocking UART: writes are buffered, and a status word exposes busy, overflow and timer state.

## Interface
Parameters:
- `DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `LED_W`, 6: LED register width.

Ports:
- `clk`  in  1: single clock.
- `resetn`  in  1: synchronous, active-low reset.
- `io_addr`  in  32: byte address from core M stage; only bits [15:2] are decoded.
- `io_wdata`  in  32: store data.
- `io_wr`  in  1: store strobe, one cycle per store.
- `io_rdata`  out  32: read data; combinational from `io_addr` and registered state.
- `leds`  out  LED_W: LED register.
- `uart_data`  out  8: FIFO head byte.
- `uart_valid`  out  1: FIFO non-empty.
- `uart_ready`  in  1: transmitter accepts the byte.
- `timer_irq`  out  1: sticky timer-match flag.

## Operation
- Word address is `wa = io_addr[15:2]`, one select bit per register:
  - `wa[0]`: LEDS.
  - `wa[1]`: UART_DATA.
  - `wa[2]`: UART_STATUS.
  - `wa[3]`: TIMER.
  - `wa[4]`: TIMER_CMP.
- Several select bits may be set at once. A write updates every selected register; a read returns the OR of every selected register. No select bit set: read returns 0, write is ignored.
- LEDS: write loads `io_wdata[LED_W-1:0]`. Read returns the value zero-extended.
- UART_DATA:
  - A write pushes `io_wdata[7:0]` if the FIFO is not full.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - There is no bypass: a push while full is dropped even if a pop happens the same cycle.
  - Reads return 0.
- UART_STATUS read:
  - bit 9 `busy` = FIFO full.
  - bit 10 `pend` = FIFO non-empty.
  - bit 11 `ovf`.
  - bit 12 `tmatch`.
  - all other bits 0.
  - Bit 9 keeps existing software polling loops valid.
  - Any write to UART_STATUS clears `ovf`.
- TX sequencing:
  - `uart_valid = !empty`; `uart_data` = head entry.
  - Pop when `uart_valid & uart_ready`.
  - Push and pop in the same cycle (FIFO not full): count unchanged, both pointers advance.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- TIMER:
  - A 32-bit counter increments every cycle and wraps 0xFFFFFFFF→0.
  - A write loads `io_wdata`; the counter then increments from that value on the following cycle.
  - Read returns the current value.
- TIMER_CMP:
  - A write loads the compare register and clears `tmatch`.
  - When counter == compare, `tmatch` is set on the next edge. Set wins over a clear in the same cycle.
  - `timer_irq = tmatch`.

## Timing
- Reset (resetn low at an edge):
  - `leds` = 0; FIFO empty (`uart_valid` = 0); `ovf` = 0; `tmatch` = 0 (`timer_irq` = 0).
  - Timer = 0; compare = 0xFFFFFFFF.
  - Reset mid-transfer discards FIFO contents; no partial byte is held.
- Write latency: the register update is visible one cycle after the `io_wr` edge.
- `io_rdata` is combinational: a read issued in cycle N returns the state registered at the start of cycle N. A write in cycle N is not visible to a read in the same cycle N.
- Push-to-`uart_valid`: 1 cycle. The transmitter may hold `uart_ready` low indefinitely; `uart_data` must stay stable while `uart_valid` is high and no pop occurs.
- Timer loaded with value V in cycle N: reads V in cycle N+1 and V+1 in cycle N+2.

## Structure
- Package `io_ctrl_pkg` holds:
  - Word-select bit indices (`IO_LEDS=0`, `IO_UART_DATA=1`, `IO_UART_STAT=2`, `IO_TIMER=3`, `IO_TIMER_CMP=4`).
  - Status bit positions (`ST_BUSY=9`, `ST_PEND=10`, `ST_OVF=11`, `ST_TMATCH=12`).
  - Compare reset value.
- Sub-module `io_tx_fifo`, parameterised by DEPTH and width 8:
  - Ports: push, push_data, pop, head, empty, full, count.
  - Synchronous active-low reset.
- Decode, registers, timer and read mux live in `io_ctrl`.

## Test plan
- Reset, then read UART_STATUS (addr 0x10) → 0; LEDS (0x04) → 0; `uart_valid` = 0; `timer_irq` = 0.
- With `uart_ready` = 0, write bytes 0x41..0x45 to 0x08 → first 4 buffered, STATUS = 0xE00 (busy, pend, ovf). Write 0x10 → STATUS = 0x600.
- Raise `uart_ready` → bytes 0x41,0x42,0x43,0x44 leave in order, one per cycle; `uart_valid` falls after the 4th; STATUS = 0.
- With FIFO at 2 entries and `uart_ready` = 1, push 0x55 in the same cycle as a pop → count stays 2; output order is preserved.
- Write TIMER (0x20) = 0xFFFFFFFE and CMP (0x40) = 1 → counter wraps to 0, then reaches 1; `timer_irq` rises the next cycle and holds. Write CMP = 0x100 → `timer_irq` falls.
- Write 0x0000003F to addr 0x0C (LEDS and UART_DATA both selected) → `leds` = 0x3F and byte 0x3F is pushed.
